// File: rtl/kirby_draw_pkg.sv
// rtl/kirby_draw_pkg.sv - shared state type, screen geometry and register indices for the sprite blitter
package kirby_draw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } draw_state_t;

    localparam int unsigned SCREEN_W   = 256;
    localparam int unsigned SCREEN_H   = 240;
    localparam int unsigned SPRITE_DIM = 16;

    localparam int unsigned REG_BITS  = 32;
    localparam int unsigned REG_CTRL  = 0;
    localparam int unsigned REG_X     = 1;
    localparam int unsigned REG_Y     = 2;
    localparam int unsigned REG_PAL   = 3;
    localparam int unsigned REG_FRAME = 4;

endpackage

// File: rtl/kirby_blit_clip.sv
// rtl/kirby_blit_clip.sv - screen-space address, clip and transparency decision for one pixel
module kirby_blit_clip
    import kirby_draw_pkg::*;
(
    input  logic [7:0]  base_x,
    input  logic [7:0]  base_y,
    input  logic [3:0]  row,
    input  logic [3:0]  col,
    input  logic [3:0]  color_idx,
    input  logic        pix_valid,
    output logic [15:0] fb_addr,
    output logic        write_en
);

    logic [8:0] x_sum;
    logic [8:0] y_sum;
    logic       on_screen;

    // Carry bit is kept so sprites hanging off the right/bottom edge clip instead of wrapping.
    assign x_sum     = {1'b0, base_x} + {5'b0, col};
    assign y_sum     = {1'b0, base_y} + {5'b0, row};
    assign on_screen = (x_sum < 9'(SCREEN_W)) && (y_sum < 9'(SCREEN_H));
    assign fb_addr   = {y_sum[7:0], x_sum[7:0]};
    assign write_en  = pix_valid && on_screen && (color_idx != 4'd0);

endmodule

// File: rtl/kirby_sprite_blitter.sv
// rtl/kirby_sprite_blitter.sv - copies one 16x16 sprite frame from ROM into the frame buffer
module kirby_sprite_blitter
    import kirby_draw_pkg::*;
(
    input  logic         CLK,
    input  logic         RESET,
    input  logic [511:0] Register_Files,
    output logic [11:0]  rom_addr,
    input  logic [3:0]   rom_data,
    output logic [15:0]  fb_addr,
    output logic [6:0]   fb_data,
    output logic         fb_we,
    output logic         busy,
    output logic         draw_done
);

    draw_state_t state;
    draw_state_t state_nx;

    logic       start_bit;
    logic       start_d;
    logic       start_edge;
    logic       load;
    logic       step;
    logic       last_pix;

    logic [7:0] x_q;
    logic [7:0] y_q;
    logic [2:0] pal_q;
    logic [3:0] frame_q;
    logic [3:0] row_q;
    logic [3:0] col_q;

    logic       pix_valid;
    logic [3:0] p_row;
    logic [3:0] p_col;

    logic       unused_reg_bits;

    assign unused_reg_bits = ^Register_Files;

    assign start_bit  = Register_Files[REG_BITS*REG_CTRL];
    assign start_edge = start_bit && !start_d;
    assign last_pix   = (row_q == 4'(SPRITE_DIM - 1)) && (col_q == 4'(SPRITE_DIM - 1));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        load      = 1'b0;
        step      = 1'b0;
        busy      = 1'b1;
        draw_done = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start_edge) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last_pix) begin
                    state_nx = FLUSH;
                end
            end
            FLUSH: state_nx = DONE;
            DONE: begin
                draw_done = 1'b1;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Counters park on the last pixel after RUN so rom_addr holds its final value.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            start_d <= 1'b0;
            x_q     <= 8'd0;
            y_q     <= 8'd0;
            pal_q   <= 3'd0;
            frame_q <= 4'd0;
            row_q   <= 4'd0;
            col_q   <= 4'd0;
        end else begin
            start_d <= start_bit;
            if (load) begin
                x_q     <= Register_Files[REG_BITS*REG_X +: 8];
                y_q     <= Register_Files[REG_BITS*REG_Y +: 8];
                pal_q   <= Register_Files[REG_BITS*REG_PAL +: 3];
                frame_q <= Register_Files[REG_BITS*REG_FRAME +: 4];
                row_q   <= 4'd0;
                col_q   <= 4'd0;
            end else if (step && !last_pix) begin
                {row_q, col_q} <= {row_q, col_q} + 8'd1;
            end
        end
    end

    // One-stage delay to line the pixel coordinates up with the returning ROM data.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pix_valid <= 1'b0;
            p_row     <= 4'd0;
            p_col     <= 4'd0;
        end else begin
            pix_valid <= step;
            p_row     <= row_q;
            p_col     <= col_q;
        end
    end

    assign rom_addr = {frame_q, row_q, col_q};
    assign fb_data  = pix_valid ? {pal_q, rom_data} : 7'd0;

    kirby_blit_clip u_clip (
        .base_x    (x_q),
        .base_y    (y_q),
        .row       (p_row),
        .col       (p_col),
        .color_idx (rom_data),
        .pix_valid (pix_valid),
        .fb_addr   (fb_addr),
        .write_en  (fb_we)
    );

endmodule

// File: tb/tb_kirby_sprite_blitter.sv
// tb/tb_kirby_sprite_blitter.sv - self-checking bench for kirby_sprite_blitter
module tb_kirby_sprite_blitter;

    localparam int M_CONST = 0;
    localparam int M_EVEN  = 1;
    localparam int M_RAND  = 2;

    localparam int P_NONE   = 0;
    localparam int P_TOGGLE = 1;
    localparam int P_XCHG   = 2;
    localparam int P_RESET  = 3;

    typedef struct {
        int x;
        int y;
        int pal;
        int frame;
        int mode;
        int pert;
        int exp_wr;
        int exp_first;
        int exp_last;
    } vec_t;

    typedef struct {
        logic [15:0] addr;
        logic [6:0]  data;
        int          cyc;
    } wr_t;

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic [511:0] regs = '0;
    logic [11:0]  rom_addr;
    logic [3:0]   rom_data = 4'd0;
    logic [15:0]  fb_addr;
    logic [6:0]   fb_data;
    logic         fb_we;
    logic         busy;
    logic         draw_done;

    logic [3:0]   rom [4096];
    wr_t          exp_q[$];
    vec_t         vecs[$];
    int           cyc = 0;
    int           errors = 0;
    int           checks = 0;

    kirby_sprite_blitter dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .Register_Files (regs),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .fb_addr        (fb_addr),
        .fb_data        (fb_data),
        .fb_we          (fb_we),
        .busy           (busy),
        .draw_done      (draw_done)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(posedge CLK) rom_data <= rom[rom_addr];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_quiet_outputs(input string tag);
        check({tag, "_fb_we"}, fb_we, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_draw_done"}, draw_done, 0);
        check({tag, "_rom_addr"}, rom_addr, 0);
        check({tag, "_fb_addr"}, fb_addr, 0);
        check({tag, "_fb_data"}, fb_data, 0);
    endtask

    task automatic run_draw(input vec_t v, input int id);
        int    k;
        int    wr_cnt;
        int    done_cnt;
        int    done_cyc;
        int    busy_cnt;
        int    first_a;
        int    last_a;
        int    after_we;
        int    after_done;
        int    after_busy;
        int    x;
        int    y;
        bit    finished;
        bit    aborted;
        logic [3:0]  d;
        logic [11:0] ra;
        wr_t   e;
        string tag;

        tag = $sformatf("v%0d", id);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                if (v.mode == M_CONST)
                    d = 4'd5;
                else if (v.mode == M_EVEN)
                    d = (c % 2 == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                else
                    d = 4'($urandom_range(0, 15));
                ra = {4'(v.frame), 4'(r), 4'(c)};
                rom[ra] = d;
            end
        end

        @(posedge CLK); #1;
        regs[0]        = 1'b0;
        regs[32 +: 32] = {24'($urandom), 8'(v.x)};
        regs[64 +: 32] = {24'($urandom), 8'(v.y)};
        regs[96 +: 32] = {29'($urandom), 3'(v.pal)};
        regs[128 +: 32] = {28'($urandom), 4'(v.frame)};
        @(posedge CLK); #1;
        regs[0] = 1'b1;
        k = cyc + 1;

        exp_q.delete();
        for (int idx = 0; idx < 256; idx++) begin
            x  = v.x + idx % 16;
            y  = v.y + idx / 16;
            ra = {4'(v.frame), 4'(idx / 16), 4'(idx % 16)};
            if (x < 256 && y < 240 && rom[ra] != 4'd0) begin
                e.addr = {8'(y), 8'(x)};
                e.data = {3'(v.pal), rom[ra]};
                e.cyc  = k + 1 + idx;
                exp_q.push_back(e);
            end
        end

        wr_cnt = 0; done_cnt = 0; done_cyc = -1; busy_cnt = 0;
        first_a = -1; last_a = -1; finished = 0; aborted = 0;
        for (int t = 0; t < 420 && !finished; t++) begin
            @(negedge CLK);
            if (busy) busy_cnt++;
            if (draw_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (fb_we) begin
                wr_cnt++;
                if (wr_cnt == 1) first_a = int'(fb_addr);
                last_a = int'(fb_addr);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s_extra_write: got addr=0x%h data=0x%h at cycle %0d, required no write",
                             tag, fb_addr, fb_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (fb_addr !== e.addr || fb_data !== e.data || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL %s_write: got addr=0x%h data=0x%h cyc=%0d, required addr=0x%h data=0x%h cyc=%0d",
                                 tag, fb_addr, fb_data, cyc, e.addr, e.data, e.cyc);
                    end
                end
            end
            if (cyc >= k + 262) begin
                finished = 1;
            end else if (v.pert == P_RESET && wr_cnt == 100) begin
                @(posedge CLK); #1;
                RESET   = 1'b1;
                regs[0] = 1'b0;
                #1;
                check_quiet_outputs({tag, "_midrst"});
                repeat (3) @(posedge CLK);
                @(negedge CLK);
                check({tag, "_midrst_hold"}, {fb_we, busy, draw_done}, 0);
                @(posedge CLK); #1;
                RESET = 1'b0;
                after_we = 0; after_done = 0; after_busy = 0;
                repeat (300) begin
                    @(negedge CLK);
                    if (fb_we) after_we++;
                    if (draw_done) after_done++;
                    if (busy) after_busy++;
                end
                check({tag, "_postrst_writes"}, after_we, 0);
                check({tag, "_postrst_done"}, after_done + done_cnt, 0);
                check({tag, "_postrst_busy"}, after_busy, 0);
                exp_q.delete();
                aborted  = 1;
                finished = 1;
            end else begin
                @(posedge CLK); #1;
                if (v.pert == P_TOGGLE) begin
                    if (cyc == k + 50) regs[0] = 1'b0;
                    if (cyc == k + 51) regs[0] = 1'b1;
                    if (cyc == k + 52) regs[0] = 1'b0;
                    if (cyc == k + 53) regs[0] = 1'b1;
                end
                if (v.pert == P_XCHG && cyc == k + 30) begin
                    regs[32 +: 8]  = ~regs[32 +: 8];
                    regs[64 +: 8]  = ~regs[64 +: 8];
                    regs[96 +: 3]  = ~regs[96 +: 3];
                    regs[128 +: 4] = ~regs[128 +: 4];
                end
            end
        end

        if (!aborted) begin
            check({tag, "_done_count"}, done_cnt, 1);
            check({tag, "_done_cycle"}, done_cyc, k + 257);
            check({tag, "_busy_cycles"}, busy_cnt, 258);
            check({tag, "_missing_writes"}, exp_q.size(), 0);
            if (v.exp_wr >= 0) begin
                check({tag, "_write_count"}, wr_cnt, v.exp_wr);
                check({tag, "_first_addr"}, first_a, v.exp_first);
                check({tag, "_last_addr"}, last_a, v.exp_last);
            end
        end
    endtask

    initial begin
        vec_t rv;
        for (int i = 0; i < 4096; i++) rom[i] = 4'($urandom_range(0, 15));

        vecs.push_back('{10, 20, 2, 3, M_CONST, P_NONE, 256, 'h140A, 'h2319});
        vecs.push_back('{250, 230, 1, 7, M_CONST, P_NONE, 60, 'hE6FA, 'hEFFF});
        vecs.push_back('{0, 0, 4, 1, M_EVEN, P_NONE, 128, 'h0001, 'h0F0F});
        vecs.push_back('{40, 50, 5, 9, M_CONST, P_TOGGLE, 256, 'h3228, 'h4137});
        vecs.push_back('{100, 60, 3, 2, M_CONST, P_XCHG, 256, 'h3C64, 'h4B73});
        vecs.push_back('{0, 224, 6, 15, M_CONST, P_NONE, 256, 'hE000, 'hEF0F});
        vecs.push_back('{255, 239, 0, 0, M_CONST, P_NONE, 1, 'hEFFF, 'hEFFF});
        vecs.push_back('{10, 20, 2, 3, M_CONST, P_RESET, -1, -1, -1});
        vecs.push_back('{10, 20, 2, 3, M_CONST, P_NONE, 256, 'h140A, 'h2319});

        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        check_quiet_outputs("reset");
        @(posedge CLK); #1;
        RESET = 1'b0;

        foreach (vecs[i]) run_draw(vecs[i], i);

        for (int i = 0; i < 5; i++) begin
            rv.x      = $urandom_range(0, 255);
            rv.y      = $urandom_range(0, 255);
            rv.pal    = $urandom_range(0, 7);
            rv.frame  = $urandom_range(0, 15);
            rv.mode   = M_RAND;
            rv.pert   = (i == 2) ? P_XCHG : P_NONE;
            rv.exp_wr = -1;
            rv.exp_first = -1;
            rv.exp_last  = -1;
            run_draw(rv, 100 + i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/kirby_sprite_blitter.md
KIRBY_SPRITE_BLITTER -- requirements
Module: kirby_sprite_blitter

Interface
REQ-001 CLK  input  1  system clock; all state changes on rising edge.
REQ-002 RESET  input  1  reset, asynchronous and active-high.
REQ-003 Register_Files  input  512  packed software register file, with Reg[n] = bits [32n+31:32n].
REQ-004 rom_addr  output  12  sprite ROM address {frame_idx[3:0], row[3:0], col[3:0]}.
REQ-005 rom_data  input  4  sprite ROM colour index, valid exactly 1 cycle after rom_addr.
REQ-006 fb_addr  output  16  frame-buffer write address {y[7:0], x[7:0]}.
REQ-007 fb_data  output  7  pixel written: {palette_idx[2:0], color_idx[3:0]}.
REQ-008 fb_we  output  1  frame-buffer write strobe, one pixel per high cycle.
REQ-009 busy  output  1  high from the cycle after an accepted start until the cycle draw_done is asserted, inclusive.
REQ-010 draw_done  output  1  one-cycle pulse when a sprite has finished drawing.
REQ-011 Register map used: Reg[0][0] start, Reg[1][7:0] Addr_X, Reg[2][7:0] Addr_Y, Reg[3][2:0] Palette_idx, Reg[4][3:0] Frame_idx; all other bits ignored.

Function
REQ-012 Start is the rising edge of Reg[0][0], detected against a 1-bit delayed copy of that bit.
REQ-013 The FSM has four states: IDLE, RUN, FLUSH, DONE.
REQ-014 IDLE -> RUN on a start edge; in the same edge, Addr_X, Addr_Y, Palette_idx and Frame_idx are latched, and row and col are cleared.
REQ-015 RUN issues one rom_addr per cycle in raster order (col 0..15 fastest, then row 0..15), 256 cycles total.
REQ-016 RUN -> FLUSH after row=15, col=15 has been issued.
REQ-017 FLUSH -> DONE after 1 cycle, allowing the last ROM read to return.
REQ-018 DONE -> IDLE after 1 cycle; draw_done=1 in DONE only.
REQ-019 Pipeline: the pixel addressed at cycle t is written at cycle t+1, with fb_addr and fb_data derived from registered copies of row and col.
REQ-020 Pixel coordinates: x = Addr_X + col and y = Addr_Y + row, each computed as a 9-bit sum.
REQ-021 Clip: fb_we is suppressed when x >= 256 or y >= 240; there is no wrap-around.
REQ-022 Transparency: fb_we is suppressed when rom_data == 0.
REQ-023 Latency: start edge at cycle N gives first rom_addr at N+1, first possible fb_we at N+2, last possible fb_we at N+257, and draw_done at N+258.
REQ-024 Start edges seen outside IDLE are ignored and not queued; the edge detector still tracks the bit.
REQ-025 Register changes during RUN do not affect the sprite in progress.
REQ-026 fb_we is 0 in IDLE and DONE; rom_addr holds its last value when not in RUN.

Reset
REQ-027 Asserting RESET forces state=IDLE and clears row, col, all latched parameters, the edge-detect register and pipeline registers.
REQ-028 Outputs during reset: fb_we=0, busy=0, draw_done=0, rom_addr=0, fb_addr=0, fb_data=0.
REQ-029 Reset mid-RUN aborts the draw immediately, with no further writes and no draw_done.

Structure
REQ-030 Shared package kirby_draw_pkg holds the following:
- the state enum;
- SCREEN_W=256, SCREEN_H=240, SPRITE_DIM=16;
- register-index constants REG_CTRL=0, REG_X=1, REG_Y=2, REG_PAL=3, REG_FRAME=4.
REQ-031 One sub-module, kirby_blit_clip, is natural: a combinational 9-bit add plus clip/transparency decision producing fb_addr and the write-enable term.

Verification
REQ-032 Basic draw: X=10, Y=20, pal=2, frame=3, ROM all 5 -> 256 writes, first fb_addr=0x140A, last fb_addr=0x2319, fb_data=0x25, draw_done at N+258.
REQ-033 Clip: X=250, Y=230 -> only x in 250..255 and y in 230..239 are written (60 writes), with no address wrapping.
REQ-034 Transparency: ROM returns 0 on even col -> exactly 128 writes, none at even col.
REQ-035 Ignored restart: toggle Reg[0][0] 0->1->0->1 during RUN -> a single 258-cycle busy window and exactly one draw_done.
REQ-036 Reset mid-RUN: assert RESET at pixel 100 -> fb_we=0 and busy=0 immediately; a new start after release draws normally.
REQ-037 Mid-draw register change: change Addr_X during RUN -> all writes use the originally latched Addr_X.
